// File: rtl/dmem_arbiter_pkg.sv
// Shared data-memory arbitration constants and the grant encoding.
package dmem_arbiter_pkg;

   localparam int unsigned DMEM_WORD_SIZE = 32;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_DMA  = 2'd2
   } grant_e;

endpackage

// File: rtl/dmem_wait_counter.sv
// Saturating count of cycles a pending DMA beat has been denied.
module dmem_wait_counter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned WAIT_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   output logic [WAIT_W-1:0] cnt
);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != WAIT_W'(MAX_WAIT)))
         cnt_d = cnt_q + WAIT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU memory stage
// (priority) and a DMA port, with a bounded-starvation forced DMA beat.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned WORD_SIZE = DMEM_WORD_SIZE,
   parameter int unsigned MAX_WAIT  = 4,
   parameter int unsigned WAIT_W    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [WORD_SIZE-1:0] cpu_addr,
   input  logic [WORD_SIZE-1:0] cpu_wdata,
   output logic [WORD_SIZE-1:0] cpu_rdata,
   output logic                 cpu_stall,
   input  logic                 dma_req,
   input  logic                 dma_we,
   input  logic [WORD_SIZE-1:0] dma_addr,
   input  logic [WORD_SIZE-1:0] dma_wdata,
   output logic                 dma_ready,
   output logic                 dma_rvalid,
   output logic [WORD_SIZE-1:0] dma_rdata,
   output logic                 mem_we,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata
);

   logic                 run_q, run_d;
   logic                 dma_rvalid_q, dma_rvalid_d;
   logic [WORD_SIZE-1:0] dma_rdata_q, dma_rdata_d;
   logic [WAIT_W-1:0]    wait_cnt;
   logic                 wait_full;
   logic                 cpu_grant, dma_grant;
   logic                 cnt_clr, cnt_inc;
   grant_e               gnt;

   assign wait_full = (wait_cnt == WAIT_W'(MAX_WAIT));

   // Grant stays NONE until the first edge after reset is released.
   always_comb begin
      gnt = GNT_NONE;
      if (run_q) begin
         if (dma_req && (!cpu_req || wait_full))
            gnt = GNT_DMA;
         else if (cpu_req)
            gnt = GNT_CPU;
      end
   end

   assign dma_grant = (gnt == GNT_DMA);
   assign cpu_grant = (gnt == GNT_CPU);
   assign cpu_stall = cpu_req && dma_grant;
   assign dma_ready = dma_grant;
   assign cpu_rdata = mem_rdata;

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (dma_grant) begin
         mem_we    = dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end else begin
         mem_we    = cpu_we && cpu_grant;
      end
   end

   assign cnt_clr = !dma_req || dma_grant;
   assign cnt_inc = run_q && dma_req && !dma_grant;

   dmem_wait_counter #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W)
   ) u_wait_counter (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .cnt (wait_cnt)
   );

   // DMA read data is captured on accept and presented for one cycle.
   always_comb begin
      run_d        = 1'b1;
      dma_rvalid_d = dma_grant && !dma_we;
      dma_rdata_d  = dma_rdata_q;
      if (dma_grant && !dma_we)
         dma_rdata_d = mem_rdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q        <= 1'b0;
         dma_rvalid_q <= 1'b0;
         dma_rdata_q  <= '0;
      end else begin
         run_q        <= run_d;
         dma_rvalid_q <= dma_rvalid_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end

   assign dma_rvalid = dma_rvalid_q;
   assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: MAX_WAIT=4 instance (a_*) and MAX_WAIT=0 instance (b_*).
module tb_dmem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_cpu_req, a_cpu_we, a_cpu_stall;
   logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
   logic        a_dma_req, a_dma_we, a_dma_ready, a_dma_rvalid, a_mem_we;
   logic [31:0] a_dma_addr, a_dma_wdata, a_dma_rdata;
   logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

   logic        b_rst, b_cpu_req, b_cpu_we, b_cpu_stall;
   logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
   logic        b_dma_req, b_dma_we, b_dma_ready, b_dma_rvalid, b_mem_we;
   logic [31:0] b_dma_addr, b_dma_wdata, b_dma_rdata;
   logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

   logic [31:0] mem_a [0:255];
   logic [31:0] mem_b [0:255];

   int errors = 0;
   int checks = 0;
   logic [31:0] dma_exp_q [$];
   logic [31:0] cpu_exp_q [$];

   dmem_arbiter #(.WORD_SIZE(32), .MAX_WAIT(4), .WAIT_W(3)) u_a (
      .clk(clk), .rst(a_rst),
      .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
      .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
      .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
      .dma_ready(a_dma_ready), .dma_rvalid(a_dma_rvalid), .dma_rdata(a_dma_rdata),
      .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
   );

   dmem_arbiter #(.WORD_SIZE(32), .MAX_WAIT(0), .WAIT_W(3)) u_b (
      .clk(clk), .rst(b_rst),
      .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
      .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
      .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
      .dma_ready(b_dma_ready), .dma_rvalid(b_dma_rvalid), .dma_rdata(b_dma_rdata),
      .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
   );

   // Single-port memory models: combinational read, write on the edge.
   assign a_mem_rdata = mem_a[a_mem_addr[7:0]];
   assign b_mem_rdata = mem_b[b_mem_addr[7:0]];

   always @(posedge clk) begin
      if (a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
      if (b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic cpu_a(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      a_cpu_req = req; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wdata;
   endtask

   task automatic dma_a(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      a_dma_req = req; a_dma_we = we; a_dma_addr = addr; a_dma_wdata = wdata;
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops expected data whenever the DUT presents a read result.
   always @(negedge clk) begin
      if (a_dma_rvalid) begin
         if (dma_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dma_rvalid_unexpected: got rdata 0x%08h expected no rvalid", a_dma_rdata);
         end else begin
            check("dma_rdata", a_dma_rdata, dma_exp_q.pop_front());
         end
      end
      if (a_rst && a_cpu_req && !a_cpu_we && !a_cpu_stall) begin
         if (cpu_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cpu_load_unexpected: got rdata 0x%08h expected no load", a_cpu_rdata);
         end else begin
            check("cpu_rdata", a_cpu_rdata, cpu_exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      a_rst = 1'b0; b_rst = 1'b0;
      cpu_a(1'b1, 1'b1, 32'h10, 32'h1);
      dma_a(1'b1, 1'b0, 32'h20, 32'h0);
      b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
      b_dma_req = 1'b0; b_dma_we = 1'b0; b_dma_addr = '0; b_dma_wdata = '0;

      // Reset: registers cleared and outputs forced despite active requests.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_we", 32'(a_mem_we), 32'h0);
      check("rst_dma_ready", 32'(a_dma_ready), 32'h0);
      check("rst_cpu_stall", 32'(a_cpu_stall), 32'h0);
      check("rst_dma_rvalid", 32'(a_dma_rvalid), 32'h0);
      check("rst_dma_rdata", a_dma_rdata, 32'h0);
      check("rst_wait_cnt", 32'(u_a.wait_cnt), 32'h0);

      drive_edge();
      a_rst = 1'b1; b_rst = 1'b1;
      cpu_a(1'b0, 1'b0, 32'h0, 32'h0);
      dma_a(1'b0, 1'b0, 32'h0, 32'h0);
      drive_edge();

      // CPU only: store then load.
      cpu_a(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      check("cpu_store_stall", 32'(a_cpu_stall), 32'h0);
      check("cpu_store_mem_we", 32'(a_mem_we), 32'h1);
      check("cpu_store_wdata", a_mem_wdata, 32'hDEADBEEF);
      drive_edge();
      cpu_a(1'b1, 1'b0, 32'h10, 32'h0);
      cpu_exp_q.push_back(32'hDEADBEEF);
      @(negedge clk);
      check("cpu_load_stall", 32'(a_cpu_stall), 32'h0);

      // DMA only: write then read back.
      drive_edge();
      cpu_a(1'b0, 1'b0, 32'h0, 32'h0);
      dma_a(1'b1, 1'b1, 32'h20, 32'h1234);
      @(negedge clk);
      check("dma_wr_ready", 32'(a_dma_ready), 32'h1);
      check("dma_wr_mem_we", 32'(a_mem_we), 32'h1);
      drive_edge();
      dma_a(1'b1, 1'b0, 32'h20, 32'h0);
      dma_exp_q.push_back(32'h1234);
      @(negedge clk);
      check("dma_rd_ready", 32'(a_dma_ready), 32'h1);
      check("dma_rvalid_after_write", 32'(a_dma_rvalid), 32'h0);
      drive_edge();
      dma_a(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("idle_mem_we", 32'(a_mem_we), 32'h0);
      check("idle_wait_cnt", 32'(u_a.wait_cnt), 32'h0);
      drive_edge();
      @(negedge clk);
      check("dma_rvalid_pulse_end", 32'(a_dma_rvalid), 32'h0);

      // Contention: continuous CPU loads, DMA write forced in cycle 4.
      for (int c = 0; c < 5; c++) begin
         drive_edge();
         cpu_a(1'b1, 1'b0, 32'h10, 32'h0);
         dma_a(1'b1, 1'b1, 32'h40, 32'h55);
         if (c < 4) cpu_exp_q.push_back(32'hDEADBEEF);
         @(negedge clk);
         check($sformatf("cont_ready_c%0d", c), 32'(a_dma_ready), (c == 4) ? 32'h1 : 32'h0);
         check($sformatf("cont_stall_c%0d", c), 32'(a_cpu_stall), (c == 4) ? 32'h1 : 32'h0);
         check($sformatf("cont_wait_c%0d", c), 32'(u_a.wait_cnt), 32'(c));
      end
      drive_edge();
      dma_a(1'b0, 1'b0, 32'h0, 32'h0);
      cpu_exp_q.push_back(32'hDEADBEEF);
      @(negedge clk);
      check("cont_wait_c5", 32'(u_a.wait_cnt), 32'h0);
      check("cont_stall_c5", 32'(a_cpu_stall), 32'h0);
      check("cont_dma_mem", mem_a[8'h40], 32'h55);

      // Forced DMA write collides with a CPU store to 0x30.
      for (int c = 0; c < 5; c++) begin
         drive_edge();
         cpu_a(1'b1, 1'b1, 32'h30, 32'hB);
         dma_a(1'b1, 1'b1, 32'h30, 32'hA);
         @(negedge clk);
         check($sformatf("coll_stall_c%0d", c), 32'(a_cpu_stall), (c == 4) ? 32'h1 : 32'h0);
         check($sformatf("coll_wdata_c%0d", c), a_mem_wdata, (c == 4) ? 32'hA : 32'hB);
      end
      drive_edge();
      dma_a(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("coll_mem_after_dma", mem_a[8'h30], 32'hA);
      check("coll_retry_mem_we", 32'(a_mem_we), 32'h1);
      check("coll_retry_stall", 32'(a_cpu_stall), 32'h0);
      drive_edge();
      cpu_a(1'b0, 1'b0, 32'h0, 32'h0);
      dma_a(1'b1, 1'b0, 32'h30, 32'h0);
      dma_exp_q.push_back(32'hB);
      @(negedge clk);
      check("coll_mem_after_retry", mem_a[8'h30], 32'hB);
      drive_edge();
      dma_a(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);

      // Reset during an accepted DMA read: the beat is dropped.
      drive_edge();
      dma_a(1'b1, 1'b0, 32'h20, 32'h0);
      @(negedge clk);
      check("rmid_accept", 32'(a_dma_ready), 32'h1);
      #1;
      a_rst = 1'b0;
      cpu_a(1'b1, 1'b1, 32'h50, 32'h77);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("rmid_rvalid_%0d", c), 32'(a_dma_rvalid), 32'h0);
         check($sformatf("rmid_wait_%0d", c), 32'(u_a.wait_cnt), 32'h0);
         check($sformatf("rmid_mem_we_%0d", c), 32'(a_mem_we), 32'h0);
         check($sformatf("rmid_ready_%0d", c), 32'(a_dma_ready), 32'h0);
      end
      drive_edge();
      a_rst = 1'b1;
      dma_a(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("rrel_before_edge_mem_we", 32'(a_mem_we), 32'h0);
      drive_edge();
      @(negedge clk);
      check("rrel_resumed_mem_we", 32'(a_mem_we), 32'h1);
      drive_edge();
      cpu_a(1'b1, 1'b0, 32'h50, 32'h0);
      cpu_exp_q.push_back(32'h77);
      drive_edge();
      cpu_a(1'b0, 1'b0, 32'h0, 32'h0);

      // MAX_WAIT=0: DMA wins immediately.
      @(negedge clk);
      check("mw0_idle_mem_we", 32'(b_mem_we), 32'h0);
      drive_edge();
      b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 32'h10;
      b_dma_req = 1'b1; b_dma_we = 1'b1; b_dma_addr = 32'h60; b_dma_wdata = 32'h99;
      @(negedge clk);
      check("mw0_dma_ready", 32'(b_dma_ready), 32'h1);
      check("mw0_cpu_stall", 32'(b_cpu_stall), 32'h1);
      check("mw0_mem_addr", b_mem_addr, 32'h60);
      drive_edge();
      b_dma_req = 1'b0;
      @(negedge clk);
      check("mw0_cpu_only_stall", 32'(b_cpu_stall), 32'h0);
      check("mw0_dma_written", mem_b[8'h60], 32'h99);
      check("mw0_no_rvalid", 32'(b_dma_rvalid), 32'h0);
      drive_edge();
      b_cpu_req = 1'b0;

      repeat (3) drive_edge();
      check("dma_queue_drained", 32'(dma_exp_q.size()), 32'h0);
      check("cpu_queue_drained", 32'(cpu_exp_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the pipeline memory stage (CPU port) and a DMA/loader port. The memory has a combinational read and a write on the clock edge. The CPU port has priority so that loads and stores stay single-cycle. A wait counter bounds DMA starvation by forcing a DMA beat and stalling the pipeline for one cycle. The block sits between the memory stage and dataMemory, which is instantiated outside the block.

## Interface
Parameters:
- WORD_SIZE, 32, data and address width (shared package constant)
- MAX_WAIT, 4, cycles a pending DMA beat may be denied before it is forced; 0 = DMA strict priority
- WAIT_W, 3, width of wait counter; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  memory stage access this cycle (load or store)
- cpu_we  in  1  CPU store
- cpu_addr  in  WORD_SIZE  CPU address
- cpu_wdata  in  WORD_SIZE  CPU store data
- cpu_rdata  out  WORD_SIZE  CPU load data, combinational
- cpu_stall  out  1  CPU access not performed this cycle; pipeline must hold
- dma_req  in  1  DMA beat pending
- dma_we  in  1  DMA write
- dma_addr  in  WORD_SIZE  DMA address
- dma_wdata  in  WORD_SIZE  DMA write data
- dma_ready  out  1  DMA beat accepted this cycle
- dma_rvalid  out  1  registered DMA read data valid
- dma_rdata  out  WORD_SIZE  registered DMA read data
- mem_we, mem_addr, mem_wdata  out  1/WORD_SIZE/WORD_SIZE  to dataMemory
- mem_rdata  in  WORD_SIZE  from dataMemory

## Operation
Grant (combinational, evaluated each cycle):
- dma_grant = dma_req & (!cpu_req | wait_cnt == MAX_WAIT).
- cpu_grant = cpu_req & !dma_grant.
- cpu_stall = cpu_req & dma_grant.
- dma_ready = dma_grant.

Memory mux:
- When DMA is granted: mem_* = DMA signals.
- Otherwise: mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_we = cpu_we & cpu_grant.
- mem_we is 0 when neither port is granted.
- cpu_rdata = mem_rdata at all times. It is valid only when cpu_grant.

Wait counter wait_cnt (WAIT_W bits):
- Increments on an edge where dma_req & !dma_grant.
- Saturates at MAX_WAIT.
- Clears to 0 on a DMA beat accept or when dma_req is low.

DMA read return:
- On an accepted DMA read (dma_grant & !dma_we), dma_rdata <= mem_rdata and dma_rvalid <= 1 on the next edge.
- Otherwise dma_rvalid <= 0, and dma_rdata holds its value.

DMA handshake:
- The DMA side holds dma_req, dma_we, dma_addr and dma_wdata stable until dma_ready.
- The beat transfers in the cycle where dma_req & dma_ready.
- Back-to-back beats are allowed, one beat per cycle.

Boundary cases:
- CPU store and forced DMA in the same cycle: the CPU store is not performed and cpu_stall=1. The CPU reissues the store on the next cycle.
- MAX_WAIT=0: DMA always wins when it requests.
- Both ports idle: mem_we=0 and the counter stays at 0.

## Timing
- CPU access latency is 0 cycles (same-cycle read, write at the edge).
- DMA read data appears 1 cycle after accept: dma_rvalid is a single-cycle pulse per read beat.
- Worst-case DMA wait with continuous cpu_req: MAX_WAIT denied cycles, then granted in cycle MAX_WAIT counted from first assertion at cycle 0.
- A forced grant stalls the CPU for exactly 1 cycle per DMA beat. The counter restarts from 0 afterwards, so at most one stall per MAX_WAIT+1 cycles under continuous CPU traffic.
- Reset asserted (rst=0):
  - Registers: wait_cnt=0, dma_rvalid=0, dma_rdata=0.
  - Outputs are forced to mem_we=0, dma_ready=0 and cpu_stall=0.
  - A beat in flight when reset asserts is dropped and no rvalid is issued.
- Outputs resume grant logic on the first edge after rst rises.

## Structure
- WORD_SIZE and the grant encoding (GNT_NONE, GNT_CPU, GNT_DMA) live in the shared processor package. Grant is exposed internally as a 2-bit encoded signal for debug.
- Sub-module dmem_wait_counter holds the saturating wait counter with clear and increment inputs. Everything else is local.

## Test plan
- CPU only: a store of 0xDEADBEEF to 0x10, then a load of 0x10 → cpu_rdata=0xDEADBEEF in the load cycle; cpu_stall=0 throughout.
- DMA only, cpu_req=0: write 0x1234 to 0x20, then read 0x20 → dma_ready=1 on both beats; dma_rvalid=1 one cycle after the read with dma_rdata=0x1234.
- Contention, MAX_WAIT=4, cpu_req held high, dma_req from cycle 0 → dma_ready=0 in cycles 0–3; dma_ready=1 and cpu_stall=1 in cycle 4; wait_cnt=0 in cycle 5.
- Forced DMA write colliding with a CPU store to the same address 0x30 (DMA data 0xA, CPU data 0xB) → after the CPU retries, memory holds 0xB; mem_we is never driven by the stalled CPU store.
- MAX_WAIT=0: dma_req and cpu_req both high → DMA granted in the same cycle and cpu_stall=1.
- Reset mid-traffic: rst low during an accepted DMA read → dma_rvalid stays 0, wait_cnt=0 and mem_we=0 while rst is low; normal grants resume after release.
